// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a valid/ready request side and a valid/ready
// result side. ADD, SUB, AND, NOTB and illegal opcodes finish in one cycle.
// MUL is an optional iterative unsigned shift-add multiplier.
//
// Optional feature macro: ALU_SEQ_MUL_EN.
//   Defined   -> opcode 100 runs the multiplier through state MUL.
//   Undefined -> opcode 100 is reported as illegal with latency 1.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   request valid          in_ready   request can be accepted
//   Ain, Bin   operands (WIDTH bits)  ALUop      operation code (3 bits)
//   out_valid  result valid           out_ready  consumer takes the result
//   out        registered result
//   Z, N, V    zero, negative and overflow flags, registered with out
//   ILL        the result came from an illegal opcode
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic [2:0]       ALUop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             Z,
  output logic             N,
  output logic             V,
  output logic             ILL
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t state;

  logic             accept;
  logic [WIDTH-1:0] add_sum;
  logic [WIDTH-1:0] sub_diff;
  logic [WIDTH-1:0] res;
  logic             res_v;
  logic             res_ill;

  // In DONE a new request may only be taken when the old result retires in
  // the same edge.
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  assign add_sum  = Ain + Bin;
  assign sub_diff = Ain - Bin;

  // Single-cycle result and flags for the operation presented this cycle.
  always_comb begin
    res     = '0;
    res_v   = 1'b0;
    res_ill = 1'b0;
    case (ALUop)
      3'b000: begin
        res   = add_sum;
        res_v = (Ain[WIDTH-1] == Bin[WIDTH-1]) && (add_sum[WIDTH-1] != Ain[WIDTH-1]);
      end
      3'b001: begin
        res   = sub_diff;
        res_v = (Ain[WIDTH-1] != Bin[WIDTH-1]) && (sub_diff[WIDTH-1] != Ain[WIDTH-1]);
      end
      3'b010: res = Ain & Bin;
      3'b011: res = ~Bin;
`ifdef ALU_SEQ_MUL_EN
      // Multiply result is produced by the iterative path, not here.
      3'b100: res = '0;
`endif
      default: res_ill = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  localparam int CNT_W = $clog2(WIDTH + 1);

  // prod holds {partial product, remaining multiplier bits}; each step adds
  // the multiplicand into the upper half when the current multiplier LSB is
  // set, then shifts the whole register right by one.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mcand;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     mul_sum;

  assign mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]}
                 + {1'b0, (prod[0] ? mcand : {WIDTH{1'b0}})};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      out   <= '0;
      Z     <= 1'b0;
      N     <= 1'b0;
      V     <= 1'b0;
      ILL   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      prod  <= '0;
      mcand <= '0;
      cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
`ifdef ALU_SEQ_MUL_EN
            if (ALUop == 3'b100) begin
              state <= MUL;
              prod  <= {{WIDTH{1'b0}}, Bin};
              mcand <= Ain;
              cnt   <= '0;
            end else begin
`else
            begin
`endif
              out   <= res;
              Z     <= (res == '0);
              N     <= res[WIDTH-1];
              V     <= res_v;
              ILL   <= res_ill;
              state <= DONE;
            end
          end else if ((state == DONE) && out_ready) begin
            state <= IDLE;
          end
        end
`ifdef ALU_SEQ_MUL_EN
        MUL: begin
          // WIDTH shift-add steps, then one edge to publish the product.
          if (cnt == CNT_W'(WIDTH)) begin
            out   <= prod[WIDTH-1:0];
            Z     <= (prod[WIDTH-1:0] == '0);
            N     <= prod[WIDTH-1];
            V     <= |prod[2*WIDTH-1:WIDTH];
            ILL   <= 1'b0;
            state <= DONE;
          end else begin
            prod <= {mul_sum, prod[WIDTH-1:1]};
            cnt  <= cnt + CNT_W'(1);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 16: datapath width in bits, legal range 4..64.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 Ain  input  WIDTH  operand A.
REQ-007 Bin  input  WIDTH  operand B.
REQ-008 ALUop  input  3  operation: 000 ADD, 001 SUB, 010 AND, 011 NOTB, 100 MUL, 101-111 illegal.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 out  output  WIDTH  registered result.
REQ-012 Z  output  1  zero flag: out == 0.
REQ-013 N  output  1  negative flag: out[WIDTH-1].
REQ-014 V  output  1  overflow flag.
REQ-015 ILL  output  1  the result came from an illegal or compiled-out opcode.

Function
REQ-016 FSM states: IDLE, MUL, DONE.
REQ-017 A request is accepted on a rising edge where in_valid && in_ready; Ain, Bin and ALUop are sampled only at that edge.
REQ-018 in_ready SHALL be 1 in IDLE, equal to out_ready in DONE, and 0 in MUL.
REQ-019 When ADD, SUB, AND, NOTB or an illegal opcode is accepted, the result SHALL be registered at the accepting edge, with next state DONE (latency 1).
REQ-020 ADD: out = (Ain+Bin) mod 2^WIDTH; V = signed overflow (operands of equal sign, result sign different).
REQ-021 SUB: out = (Ain-Bin) mod 2^WIDTH; V = operand signs differ and result sign differs from Ain.
REQ-022 AND: out = Ain & Bin. NOTB: out = ~Bin, with Ain ignored. For both, V = 0.
REQ-023 MUL is an unsigned shift-add operation over exactly WIDTH cycles in state MUL, followed by DONE.
- out_valid SHALL rise WIDTH+1 edges after the accepting edge.
- out = low WIDTH bits of the product.
- V = 1 if the upper WIDTH bits of the product are nonzero.
REQ-024 Illegal opcode: out = 0, Z = 1, N = 0, V = 0, ILL = 1. For all legal ops, ILL = 0.
REQ-025 Z and N SHALL be derived from the registered out; all of Z, N, V, ILL SHALL be registered with out.
REQ-026 out_valid = 1 exactly in DONE.
REQ-027 While out_valid && !out_ready, out, Z, N, V and ILL SHALL be held stable.
REQ-028 DONE with out_ready and no accepted request SHALL go to IDLE, with out_valid = 0 on the next cycle.
REQ-029 DONE with out_ready and an accepted request SHALL retire the old result and load the new one in the same edge, giving throughput of 1 op/cycle for single-cycle ops.
REQ-030 out and flags SHALL keep their last value when out_valid = 0.

Reset
REQ-031 Asserting reset_n = 0 at any time, including mid-MUL or in DONE with an unconsumed result, SHALL immediately force:
- state IDLE;
- out = 0, Z = 0, N = 0, V = 0, ILL = 0;
- out_valid = 0, in_ready = 1 after release.
REQ-032 An in-flight operation SHALL be discarded on reset with no partial result ever presented.

Configuration
REQ-033 Macro ALU_SEQ_MUL_EN, when defined, SHALL compile in the MUL state and the iterative multiplier.
REQ-034 Without ALU_SEQ_MUL_EN, opcode 100 SHALL be treated as illegal per REQ-024 with latency 1, and state MUL SHALL be unreachable and may be absent.

Verification (WIDTH = 16)
REQ-035 ADD 0x0E12 + 0x6F04 (3602 + 28420) -> out=0x7D16, Z=0, N=0, V=0, out_valid one cycle after accept.
REQ-036 SUB 0x01CF - 0x01CF -> out=0x0000, Z=1, then SUB 0x0064 - 0x8064 -> out=0x8000, N=1, V=1. Drive both back-to-back with out_ready=1 and require in_ready to stay 1.
REQ-037 MUL 300*200 (ALU_SEQ_MUL_EN defined) -> out=0xEA60, N=1, V=0, out_valid exactly 17 edges after accept, in_ready=0 throughout. MUL 0x0100*0x0100 -> out=0x0000, Z=1, V=1.
REQ-038 Backpressure: AND 0xCB74 & 0x3698 with out_ready=0 for 5 cycles -> out=0x0210 stable, in_ready=0. Raising out_ready retires the result.
REQ-039 reset_n pulsed low during cycle 8 of a MUL -> out_valid=0, out=0, in_ready=1. Next request ADD 1+1 -> out=0x0002.
REQ-040 ALUop 101, and ALUop 100 without ALU_SEQ_MUL_EN -> out=0, Z=1, ILL=1, latency 1.
